// File: rtl/hello_scroller.sv
`timescale 1ns/1ps
// hello_scroller: scrolls a writable message of 3-bit character codes across N_DIGITS
// active-low seven-segment digits. Define HELLO_SCROLL_BLINK_EN to add the blink input.
module hello_scroller #(
  parameter int N_DIGITS  = 5,
  parameter int MSG_LEN   = 8,
  parameter int TICK_DIV  = 25000000,
  parameter int WRAP_HOLD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       dir,
  input  logic                       step,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [2:0]                 wr_data,
`ifdef HELLO_SCROLL_BLINK_EN
  input  logic                       blink,
`endif
  output logic [7*N_DIGITS-1:0]      hex,
  output logic [$clog2(MSG_LEN)-1:0] offset,
  output logic                       tick
);
  localparam int AW = $clog2(MSG_LEN);
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (WRAP_HOLD > 1) ? $clog2(WRAP_HOLD) : 1;

  typedef enum logic [1:0] {STOP, SCROLL, HOLD} state_t;

  state_t                state;
  logic [PW-1:0]         presc;
  logic [HW-1:0]         hold_cnt;
  logic [2:0]            msg [MSG_LEN];
  logic [7*N_DIGITS-1:0] disp;
  logic                  force_blank;

  function automatic logic [6:0] seg_of(input logic [2:0] code);
    case (code)
      3'b000:  return 7'b1001000;
      3'b001:  return 7'b0110000;
      3'b010:  return 7'b1110001;
      3'b011:  return 7'b0000001;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] reset_code(input int i);
    case (i)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b010;
      4:       return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [AW-1:0] advance(input logic [AW-1:0] cur, input logic d);
    if (!d) return (int'(cur) == MSG_LEN - 1) ? '0 : cur + 1'b1;
    else    return (cur == '0) ? AW'(MSG_LEN - 1) : cur - 1'b1;
  endfunction

  function automatic logic [AW-1:0] msg_idx(input logic [AW-1:0] off, input int j);
    return AW'((int'(off) + j) % MSG_LEN);
  endfunction

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Out-of-range addresses exist only when MSG_LEN is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= reset_code(i);
    end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
      msg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STOP;
      offset   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        STOP: begin
          if (run)       state  <= SCROLL;
          else if (step) offset <= advance(offset, dir);
        end
        SCROLL: begin
          if (!run) begin
            state <= STOP;
          end else if (tick) begin
            offset <= advance(offset, dir);
            if (advance(offset, dir) == '0 && WRAP_HOLD > 0) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end
        HOLD: begin
          // The tick that ends the hold only re-enters SCROLL; the next tick advances.
          if (!run) begin
            state    <= STOP;
            hold_cnt <= '0;
          end else if (tick) begin
            if (int'(hold_cnt) == WRAP_HOLD - 1) begin
              state    <= SCROLL;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= STOP;
      endcase
    end
  end

  // Leftmost digit (N_DIGITS-1) shows the entry at the current offset.
  always_comb begin
    disp = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      disp[7*k +: 7] = seg_of(msg[msg_idx(offset, N_DIGITS - 1 - k)]);
    end
  end

`ifdef HELLO_SCROLL_BLINK_EN
  logic phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    phase <= 1'b0;
    else if (tick) phase <= ~phase;
  end

  assign force_blank = blink & phase;
`else
  assign force_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           hex <= '1;
    else if (force_blank) hex <= '1;
    else                  hex <= disp;
  end
endmodule

// File: tb/tb_hello_scroller.sv
`timescale 1ns/1ps
// tb_hello_scroller: directed checks of hello_scroller (TICK_DIV=4, WRAP_HOLD=2, N_DIGITS=5)
// on an 8-entry instance and a 9-entry instance used for address-range and wrap cases.
module tb_hello_scroller;
  localparam logic [6:0]  SH = 7'b1001000;
  localparam logic [6:0]  SE = 7'b0110000;
  localparam logic [6:0]  SL = 7'b1110001;
  localparam logic [6:0]  SO = 7'b0000001;
  localparam logic [6:0]  SB = 7'b1111111;
  localparam logic [34:0] HELLO = {SH, SE, SL, SL, SO};
  localparam logic [34:0] BLANK = {SB, SB, SB, SB, SB};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, dir = 1'b0, step = 1'b0, wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0, wr_data = 3'd0;
  logic [34:0] hex;
  logic [2:0]  offset;
  logic        tick;
  logic        step9 = 1'b0, wr_en9 = 1'b0;
  logic [3:0]  wr_addr9 = 4'd0;
  logic [2:0]  wr_data9 = 3'd0;
  logic [34:0] hex9;
  logic [3:0]  offset9;
  logic        tick9;
`ifdef HELLO_SCROLL_BLINK_EN
  logic        blink = 1'b0;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hello_scroller #(.N_DIGITS(5), .MSG_LEN(8), .TICK_DIV(4), .WRAP_HOLD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef HELLO_SCROLL_BLINK_EN
    .blink(blink),
`endif
    .hex(hex), .offset(offset), .tick(tick)
  );

  hello_scroller #(.N_DIGITS(5), .MSG_LEN(9), .TICK_DIV(4), .WRAP_HOLD(2)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .run(1'b0), .dir(1'b0), .step(step9),
    .wr_en(wr_en9), .wr_addr(wr_addr9), .wr_data(wr_data9),
`ifdef HELLO_SCROLL_BLINK_EN
    .blink(1'b0),
`endif
    .hex(hex9), .offset(offset9), .tick(tick9)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a tick, then lets the edge that consumes it pass.
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 12);
    chk("tick_wait", 64'(tick), 64'(1));
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and release
    #12;
    chk("rst_hex", 64'(hex), 64'(BLANK));
    chk("rst_offset", 64'(offset), 64'(0));
    chk("rst_tick", 64'(tick), 64'(0));
    cyc();
    rst_n = 1'b1;
    chk("hex_cycle0", 64'(hex), 64'(BLANK));
    cyc();
    chk("hex_hello", 64'(hex), 64'(HELLO));
    chk("offset_idle", 64'(offset), 64'(0));
    chk("tick_k1", 64'(tick), 64'(0));
    for (int k = 2; k <= 8; k++) begin
      cyc();
      chk("tick_period", 64'(tick), 64'(k % 4 == 3));
    end

    // Auto-scroll left with wrap hold
    run = 1'b1;
    dir = 1'b0;
    next_tick();
    chk("scroll_off1", 64'(offset), 64'(1));
    cyc();
    chk("hex_off1", 64'(hex), 64'({SE, SL, SL, SO, SB}));
    for (int i = 2; i <= 7; i++) begin
      next_tick();
      chk("scroll_off", 64'(offset), 64'(i));
    end
    next_tick();
    chk("wrap_off0", 64'(offset), 64'(0));
    next_tick();
    chk("hold_tick1", 64'(offset), 64'(0));
    next_tick();
    chk("hold_tick2", 64'(offset), 64'(0));
    next_tick();
    chk("after_hold", 64'(offset), 64'(1));

    // Stepping right while stopped
    run = 1'b0;
    dir = 1'b1;
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_to0", 64'(offset), 64'(0));
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_wrap7", 64'(offset), 64'(7));
    cyc();
    chk("hex_off7", 64'(hex), 64'({SB, SH, SE, SL, SL}));
    run = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_run_ignored", 64'(offset), 64'(7));
    run = 1'b0;
    cyc();

    // Write coinciding with an advance
    dir = 1'b0;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_left_wrap", 64'(offset), 64'(0));
    step = 1'b1;
    wr_en = 1'b1;
    wr_addr = 3'd5;
    wr_data = 3'b011;
    cyc();
    step = 1'b0;
    wr_en = 1'b0;
    chk("wr_step_off", 64'(offset), 64'(1));
    cyc();
    chk("hex_written", 64'(hex), 64'({SE, SL, SL, SO, SO}));

    // Reset while holding at offset 0 with a modified message
    run = 1'b1;
    for (int i = 0; i < 7; i++) next_tick();
    chk("hold_reach0", 64'(offset), 64'(0));
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 3'b011;
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("hex_modified", 64'(hex), 64'({SO, SE, SL, SL, SO}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_hex", 64'(hex), 64'(BLANK));
    chk("async_offset", 64'(offset), 64'(0));
    chk("async_tick", 64'(tick), 64'(0));
    run = 1'b0;
`ifdef HELLO_SCROLL_BLINK_EN
    blink = 1'b1;
`endif
    cyc();
    cyc();
    chk("held_rst_hex", 64'(hex), 64'(BLANK));
    rst_n = 1'b1;
    chk("rel_cycle0", 64'(hex), 64'(BLANK));

    // Display after release: steady, or blinking in the blink build
    for (int k = 1; k <= 12; k++) begin
      cyc();
`ifdef HELLO_SCROLL_BLINK_EN
      chk("blink_hex", 64'(hex), 64'((((k - 1) / 4) % 2 == 1) ? BLANK : HELLO));
`else
      chk("steady_hex", 64'(hex), 64'(HELLO));
`endif
      chk("tick_after_rst", 64'(tick), 64'(k % 4 == 3));
      chk("tick9_after_rst", 64'(tick9), 64'(k % 4 == 3));
    end
    chk("rel_offset", 64'(offset), 64'(0));
    chk("hex9_hello", 64'(hex9), 64'(HELLO));

    // Nine-entry instance: out-of-range write, held step, wrap at 8
    wr_en9 = 1'b1;
    wr_addr9 = 4'd9;
    wr_data9 = 3'b011;
    cyc();
    wr_addr9 = 4'd8;
    cyc();
    wr_en9 = 1'b0;
    step9 = 1'b1;
    repeat (4) cyc();
    step9 = 1'b0;
    chk("held_step9", 64'(offset9), 64'(4));
    cyc();
    chk("hex9_off4", 64'(hex9), 64'({SO, SB, SB, SB, SO}));
    step9 = 1'b1;
    repeat (5) cyc();
    step9 = 1'b0;
    chk("wrap9", 64'(offset9), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
